// File: rtl/counter_bank.sv
// counter_bank: NCH prescaled up/down counters with sticky overflow flags
// and a coherent snapshot bank read back 16 bits at a time.
module counter_bank #(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int PW  = 16
) (
    input  logic           clk1,
    input  logic           reset,
    input  logic [NCH-1:0] trig_clr,
    input  logic [NCH-1:0] trig_load,
    input  logic [NCH-1:0] trig_up,
    input  logic [NCH-1:0] trig_dn,
    input  logic [CW-1:0]  load_val,
    input  logic [NCH-1:0] mode,
    input  logic [NCH-1:0] dir,
    input  logic [NCH-1:0] sat,
    input  logic [PW-1:0]  prescale,
    input  logic           snap_req,
    input  logic [2:0]     rd_ch,
    input  logic           rd_word,
    output logic [15:0]    rd_data,
    output logic           snap_valid,
    output logic [NCH-1:0] ovf
);
    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } snap_state_t;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0] PRE_ONE = PW'(1);

    logic [PW-1:0]          pre_q;
    logic                   tick;
    logic [NCH-1:0][CW-1:0] cnt_q;
    logic [NCH-1:0][CW-1:0] cnt_d;
    logic [NCH-1:0][CW-1:0] snap_q;
    logic [NCH-1:0]         ovf_d;
    logic [NCH-1:0]         step_up;
    logic [NCH-1:0]         step_dn;
    logic [31:0]            rd_ext;
    logic [15:0]            rd_d;
    snap_state_t            snap_st;

    // A count at or above the period limit is the last cycle of a period.
    assign tick = (pre_q >= prescale);

    // Prescaler period counter, restarts on the edge after each tick.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_ONE;
        end
    end

    // Per-channel step request: ticks in free-run, pulses when triggered.
    always_comb begin
        step_up = '0;
        step_dn = '0;
        for (int i = 0; i < NCH; i++) begin
            if (mode[i]) begin
                step_up[i] = tick & ~dir[i];
                step_dn[i] = tick & dir[i];
            end else begin
                step_up[i] = trig_up[i] & ~trig_dn[i];
                step_dn[i] = trig_dn[i] & ~trig_up[i];
            end
        end
    end

    // Next count and flag: clear beats load beats the step.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf;
        for (int i = 0; i < NCH; i++) begin
            if (trig_clr[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (trig_load[i]) begin
                cnt_d[i] = load_val;
            end else if (step_up[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                    if (!sat[i]) begin
                        cnt_d[i] = '0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (step_dn[i]) begin
                if (cnt_q[i] == '0) begin
                    ovf_d[i] = 1'b1;
                    if (!sat[i]) begin
                        cnt_d[i] = CNT_MAX;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ovf   <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf   <= ovf_d;
        end
    end

    // Snapshot FSM: captures pre-update counts of every channel at once.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            snap_st    <= EMPTY;
            snap_valid <= 1'b0;
            snap_q     <= '0;
        end else begin
            unique case (snap_st)
                EMPTY: begin
                    if (snap_req) begin
                        snap_q     <= cnt_q;
                        snap_st    <= VALID;
                        snap_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (snap_req) begin
                        snap_q <= cnt_q;
                    end
                end
                default: begin
                    snap_st    <= EMPTY;
                    snap_valid <= 1'b0;
                end
            endcase
        end
    end

    // Readout word select; unmatched channels read as zero.
    always_comb begin
        rd_ext = '0;
        rd_d   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == 3'(i)) begin
                rd_ext = 32'(snap_q[i]);
                rd_d   = rd_word ? rd_ext[31:16] : rd_ext[15:0];
            end
        end
    end

    // Registered readout port.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_d;
        end
    end

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: arithmetic reference model, per-cycle output compare,
// directed literal scenarios and a randomized soak.
`timescale 1ns/1ps
module tb_counter_bank;
    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int PW  = 16;
    localparam longint MAXV = (longint'(1) << CW) - 1;

    logic           clk1      = 1'b0;
    logic           reset     = 1'b1;
    logic [NCH-1:0] trig_clr  = '0;
    logic [NCH-1:0] trig_load = '0;
    logic [NCH-1:0] trig_up   = '0;
    logic [NCH-1:0] trig_dn   = '0;
    logic [CW-1:0]  load_val  = '0;
    logic [NCH-1:0] mode      = '0;
    logic [NCH-1:0] dir       = '0;
    logic [NCH-1:0] sat       = '0;
    logic [PW-1:0]  prescale  = '0;
    logic           snap_req  = 1'b0;
    logic [2:0]     rd_ch     = '0;
    logic           rd_word   = 1'b0;
    logic [15:0]    rd_data;
    logic           snap_valid;
    logic [NCH-1:0] ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk1 = ~clk1;

    counter_bank #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
        .clk1       (clk1),
        .reset      (reset),
        .trig_clr   (trig_clr),
        .trig_load  (trig_load),
        .trig_up    (trig_up),
        .trig_dn    (trig_dn),
        .load_val   (load_val),
        .mode       (mode),
        .dir        (dir),
        .sat        (sat),
        .prescale   (prescale),
        .snap_req   (snap_req),
        .rd_ch      (rd_ch),
        .rd_word    (rd_word),
        .rd_data    (rd_data),
        .snap_valid (snap_valid),
        .ovf        (ovf)
    );

    longint      m_cnt  [NCH];
    longint      m_snap [NCH];
    bit          m_ovf  [NCH];
    int          m_pre;
    bit          m_sv;
    logic [15:0] m_rd;
    bit          m_tick;
    longint      m_nv;
    int          m_d;
    int          m_idx;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0] m_ovf_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    // Reference model: plain arithmetic on the architectural state.
    always @(posedge clk1 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i]  = 0;
                m_snap[i] = 0;
                m_ovf[i]  = 0;
            end
            m_pre = 0;
            m_sv  = 0;
            m_rd  = '0;
        end else begin
            m_tick = (m_pre >= int'(prescale));
            m_pre  = m_tick ? 0 : m_pre + 1;
            m_idx  = int'(rd_ch);
            if (m_idx < NCH)
                m_rd = 16'((m_snap[m_idx] >> (rd_word ? 16 : 0)) & 64'hFFFF);
            else
                m_rd = '0;
            if (snap_req) begin
                for (int i = 0; i < NCH; i++) m_snap[i] = m_cnt[i];
                m_sv = 1;
            end
            for (int i = 0; i < NCH; i++) begin
                if (trig_clr[i]) begin
                    m_cnt[i] = 0;
                    m_ovf[i] = 0;
                end else if (trig_load[i]) begin
                    m_cnt[i] = longint'(load_val);
                end else begin
                    if (mode[i]) m_d = m_tick ? (dir[i] ? -1 : 1) : 0;
                    else m_d = int'(trig_up[i]) - int'(trig_dn[i]);
                    m_nv = m_cnt[i] + m_d;
                    if (m_nv < 0 || m_nv > MAXV) begin
                        m_ovf[i] = 1;
                        if (!sat[i]) m_cnt[i] = m_nv & MAXV;
                    end else begin
                        m_cnt[i] = m_nv;
                    end
                end
            end
        end
    end

    // Every-cycle compare of all outputs against the model.
    always @(negedge clk1) begin
        chk("rd_data", 32'(rd_data), 32'(m_rd));
        chk("snap_valid", 32'(snap_valid), 32'(m_sv));
        chk("ovf", 32'(ovf), 32'(m_ovf_vec()));
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic pulse(input logic [NCH-1:0] c, input logic [NCH-1:0] l,
                         input logic [NCH-1:0] u, input logic [NCH-1:0] d);
        trig_clr  = c;
        trig_load = l;
        trig_up   = u;
        trig_dn   = d;
        step();
        trig_clr  = '0;
        trig_load = '0;
        trig_up   = '0;
        trig_dn   = '0;
    endtask

    task automatic read_ch(input int ch, output logic [31:0] v);
        snap_req = 1'b1;
        rd_ch    = 3'(ch);
        rd_word  = 1'b0;
        step();
        snap_req = 1'b0;
        step();
        v[15:0]  = rd_data;
        rd_word  = 1'b1;
        step();
        v[31:16] = rd_data;
    endtask

    logic [31:0] v;
    logic [15:0] samp [16];
    int          ones;
    int          sel;

    initial begin
        repeat (3) step();
        chk("reset_rd_data", 32'(rd_data), 32'h0);
        chk("reset_snap_valid", 32'(snap_valid), 32'h0);
        chk("reset_ovf", 32'(ovf), 32'h0);
        reset = 1'b0;
        step();
        rd_ch = 3'd6;
        step();
        step();
        chk("oob_read_pre", 32'(rd_data), 32'h0);
        chk("snap_valid_pre", 32'(snap_valid), 32'h0);

        // Triggered wrap on channel 0.
        load_val = 32'hFFFF_FFFE;
        pulse('0, 4'b0001, '0, '0);
        read_ch(0, v);
        chk("wrap_load", v, 32'hFFFF_FFFE);
        chk("snap_valid_set", 32'(snap_valid), 32'h1);
        pulse('0, '0, 4'b0001, '0);
        read_ch(0, v);
        chk("wrap_max", v, 32'hFFFF_FFFF);
        chk("wrap_no_ovf", 32'(ovf[0]), 32'h0);
        pulse('0, '0, 4'b0001, '0);
        read_ch(0, v);
        chk("wrap_zero", v, 32'h0);
        chk("wrap_ovf", 32'(ovf[0]), 32'h1);
        rd_ch = 3'd6;
        step();
        step();
        chk("oob_read_post", 32'(rd_data), 32'h0);

        // Free-run saturating down-count on channel 1, period 4.
        prescale = 16'd3;
        sat[1]   = 1'b1;
        dir[1]   = 1'b1;
        load_val = 32'd2;
        pulse('0, 4'b0010, '0, '0);
        mode[1]  = 1'b1;
        snap_req = 1'b1;
        rd_ch    = 3'd1;
        rd_word  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            samp[k] = rd_data;
        end
        snap_req = 1'b0;
        ones = 0;
        for (int k = 0; k < 16; k++) if (samp[k] == 16'd1) ones++;
        chk("sat_one_period", 32'(ones), 32'd4);
        chk("sat_floor_a", 32'(samp[12]), 32'h0);
        chk("sat_floor_b", 32'(samp[15]), 32'h0);
        chk("sat_ovf", 32'(ovf[1]), 32'h1);

        // Priority on channel 2, with the flag set beforehand.
        load_val = 32'd0;
        pulse('0, 4'b0100, '0, '0);
        pulse('0, '0, '0, 4'b0100);
        load_val = 32'd5;
        pulse('0, 4'b0100, '0, '0);
        chk("load_keeps_ovf", 32'(ovf[2]), 32'h1);
        pulse(4'b0100, 4'b0100, 4'b0100, '0);
        read_ch(2, v);
        chk("prio_clr", v, 32'h0);
        chk("prio_clr_ovf", 32'(ovf[2]), 32'h0);
        load_val = 32'd7;
        pulse('0, 4'b0100, '0, '0);
        pulse('0, '0, 4'b0100, 4'b0100);
        read_ch(2, v);
        chk("up_dn_hold", v, 32'd7);

        // Coherent snapshot across the 16-bit word boundary.
        load_val = 32'h0000_FFF0;
        pulse('0, 4'b0001, '0, '0);
        prescale = 16'd0;
        dir[0]   = 1'b0;
        mode[0]  = 1'b1;
        repeat (16) step();
        snap_req = 1'b1;
        rd_ch    = 3'd0;
        rd_word  = 1'b1;
        step();
        snap_req = 1'b0;
        step();
        chk("snap_hi", 32'(rd_data), 32'h0001);
        rd_word = 1'b0;
        step();
        chk("snap_lo", 32'(rd_data), 32'h0000);
        mode[0] = 1'b0;

        // Reset between edges while channel 3 holds 0x1234.
        prescale = 16'hFFFF;
        load_val = 32'h1234;
        pulse('0, 4'b1000, '0, '0);
        mode[3] = 1'b1;
        dir[3]  = 1'b0;
        read_ch(3, v);
        chk("pre_reset_val", v, 32'h1234);
        rd_word = 1'b0;
        step();
        chk("pre_reset_rd", 32'(rd_data), 32'h1234);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rd_data", 32'(rd_data), 32'h0);
        chk("async_snap_valid", 32'(snap_valid), 32'h0);
        chk("async_ovf", 32'(ovf), 32'h0);
        prescale = 16'd0;
        step();
        reset = 1'b0;
        repeat (5) step();
        read_ch(3, v);
        chk("resume_from_zero", v, 32'd5);

        // Randomized soak against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                #2;
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) mode = NCH'($urandom);
            if ($urandom_range(0, 15) == 0) dir = NCH'($urandom);
            if ($urandom_range(0, 15) == 0) sat = NCH'($urandom);
            if ($urandom_range(0, 31) == 0) prescale = PW'($urandom_range(0, 3));
            sel = $urandom_range(0, 4);
            case (sel)
                0: load_val = 32'h0;
                1: load_val = 32'h1;
                2: load_val = 32'hFFFF_FFFF;
                3: load_val = 32'hFFFF_FFFE;
                default: load_val = $urandom;
            endcase
            trig_clr  = NCH'($urandom & $urandom & $urandom & $urandom);
            trig_load = NCH'($urandom & $urandom & $urandom);
            trig_up   = NCH'($urandom & $urandom);
            trig_dn   = NCH'($urandom & $urandom);
            snap_req  = ($urandom_range(0, 3) == 0);
            rd_ch     = 3'($urandom_range(0, 7));
            rd_word   = 1'($urandom);
            step();
        end
        trig_clr  = '0;
        trig_load = '0;
        trig_up   = '0;
        trig_dn   = '0;
        snap_req  = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
